// File: rtl/snake_audio_pkg.sv
// Shared constants for the Snake audio path: note dividers at 50 MHz,
// sound-effect sequence codes and sequencer FSM state encodings.
package snake_audio_pkg;

  // Square-wave divider counts at 50 MHz; 0 keeps the beeper silent.
  localparam logic [17:0] DO   = 18'd190839;
  localparam logic [17:0] MI   = 18'd151514;
  localparam logic [17:0] SO   = 18'd127550;
  localparam logic [17:0] HDO  = 18'd95419;
  localparam logic [17:0] REST = 18'd0;

  // Sequence selector, also visible to game logic as cur_seq.
  typedef enum logic [1:0] {
    SEQ_NONE  = 2'd0,
    SEQ_EAT   = 2'd1,
    SEQ_START = 2'd2,
    SEQ_DIE   = 2'd3
  } seq_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_e;

  // Bit positions inside the pending-request vector.
  localparam int PEND_EAT   = 0;
  localparam int PEND_START = 1;
  localparam int PEND_DIE   = 2;

endpackage

// File: rtl/snake_sfx_sequencer_if.sv
// Bundle between game logic and the sound-effect sequencer.
//
// Signalling: req_eat/req_start/req_die are fire-and-forget one-cycle
// pulses sampled on each rising sys_clk edge; there is no ready or
// back-pressure, the sequencer latches every pulse into a pending bit and
// pulses arriving while that bit is still pending merge into one request.
// mute is a level. freq_data, busy, cur_seq and dbg_state are registered
// status outputs, valid every cycle.
interface snake_sfx_sequencer_if;
  import snake_audio_pkg::*;

  logic        req_eat;
  logic        req_start;
  logic        req_die;
  logic        mute;
  logic [17:0] freq_data;
  logic        busy;
  logic [1:0]  cur_seq;
  state_e      dbg_state;

  // Game logic / test side.
  modport master (
    output req_eat, req_start, req_die, mute,
    input  freq_data, busy, cur_seq, dbg_state
  );

  // Sequencer side.
  modport slave (
    input  req_eat, req_start, req_die, mute,
    output freq_data, busy, cur_seq, dbg_state
  );

endinterface

// File: rtl/snake_sfx_rom.sv
// Note table for the sound effects: (sequence, step) -> (divider, duration).
// A duration of 0 marks the end of a sequence.
module snake_sfx_rom (
  input  logic [1:0]  seq_i,
  input  logic [2:0]  idx_i,
  output logic [17:0] freq_o,
  output logic [2:0]  dur_o
);
  import snake_audio_pkg::*;

  // Pure lookup; anything outside the table reads as the end marker.
  always_comb begin
    freq_o = REST;
    dur_o  = 3'd0;
    case ({seq_i, idx_i})
      {SEQ_EAT,   3'd0}: begin freq_o = SO;  dur_o = 3'd1; end
      {SEQ_EAT,   3'd1}: begin freq_o = HDO; dur_o = 3'd2; end
      {SEQ_START, 3'd0}: begin freq_o = DO;  dur_o = 3'd1; end
      {SEQ_START, 3'd1}: begin freq_o = MI;  dur_o = 3'd1; end
      {SEQ_START, 3'd2}: begin freq_o = SO;  dur_o = 3'd1; end
      {SEQ_START, 3'd3}: begin freq_o = HDO; dur_o = 3'd3; end
      {SEQ_DIE,   3'd0}: begin freq_o = SO;  dur_o = 3'd2; end
      {SEQ_DIE,   3'd1}: begin freq_o = MI;  dur_o = 3'd2; end
      {SEQ_DIE,   3'd2}: begin freq_o = DO;  dur_o = 3'd4; end
      default:           begin freq_o = REST; dur_o = 3'd0; end
    endcase
  end

endmodule

// File: rtl/snake_sfx_sequencer.sv
// Sound-effect sequencer: latches game event pulses, arbitrates them
// (die > start > eat), and steps through the selected note list, holding
// each note for dur units followed by a short silent gap. A die request
// aborts an eat or start sequence in progress.
module snake_sfx_sequencer #(
  parameter logic [24:0] UNIT_CYCLES = 25'd2499999,
  parameter logic [24:0] GAP_CYCLES  = 25'd249999
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  snake_sfx_sequencer_if.slave   bus
);
  import snake_audio_pkg::*;

  state_e      state_q,    state_d;
  seq_e        cur_seq_q,  cur_seq_d;
  logic [2:0]  pend_q,     pend_d;
  logic [2:0]  pend_clr;
  logic [2:0]  idx_q,      idx_d;
  logic [17:0] note_q,     note_d;
  logic [17:0] freq_q,     freq_d;
  logic [2:0]  dur_cnt_q,  dur_cnt_d;
  logic [24:0] unit_cnt_q, unit_cnt_d;
  logic [24:0] gap_cnt_q,  gap_cnt_d;
  logic        busy_q,     busy_d;
  logic        preempt;

  logic [17:0] rom_freq;
  logic [2:0]  rom_dur;

  snake_sfx_rom u_rom (
    .seq_i  (cur_seq_q),
    .idx_i  (idx_q),
    .freq_o (rom_freq),
    .dur_o  (rom_dur)
  );

  // A pending die cuts short anything except another die sequence.
  assign preempt = pend_q[PEND_DIE] && (state_q != IDLE) &&
                   ((cur_seq_q == SEQ_EAT) || (cur_seq_q == SEQ_START));

  // Next-state logic for the sequencer and its counters.
  always_comb begin
    state_d    = state_q;
    cur_seq_d  = cur_seq_q;
    idx_d      = idx_q;
    note_d     = note_q;
    dur_cnt_d  = dur_cnt_q;
    unit_cnt_d = unit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    busy_d     = busy_q;
    pend_clr   = 3'b000;

    if (preempt) begin
      // The interrupted sequence is dropped, never resumed.
      state_d            = LOAD;
      cur_seq_d          = SEQ_DIE;
      idx_d              = 3'd0;
      note_d             = REST;
      dur_cnt_d          = 3'd0;
      unit_cnt_d         = 25'd0;
      gap_cnt_d          = 25'd0;
      busy_d             = 1'b1;
      pend_clr[PEND_DIE] = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_q[PEND_DIE]) begin
            cur_seq_d          = SEQ_DIE;
            pend_clr[PEND_DIE] = 1'b1;
          end else if (pend_q[PEND_START]) begin
            cur_seq_d            = SEQ_START;
            pend_clr[PEND_START] = 1'b1;
          end else if (pend_q[PEND_EAT]) begin
            cur_seq_d          = SEQ_EAT;
            pend_clr[PEND_EAT] = 1'b1;
          end else begin
            cur_seq_d = SEQ_NONE;
          end
          if (|pend_q) begin
            idx_d   = 3'd0;
            busy_d  = 1'b1;
            state_d = LOAD;
          end else begin
            busy_d  = 1'b0;
          end
        end

        LOAD: begin
          if (rom_dur == 3'd0) begin
            // End marker: release the beeper and go back to arbitration.
            note_d    = REST;
            busy_d    = 1'b0;
            cur_seq_d = SEQ_NONE;
            state_d   = IDLE;
          end else begin
            note_d     = rom_freq;
            dur_cnt_d  = rom_dur;
            unit_cnt_d = 25'd0;
            state_d    = PLAY;
          end
        end

        PLAY: begin
          if (unit_cnt_q == UNIT_CYCLES) begin
            unit_cnt_d = 25'd0;
            dur_cnt_d  = dur_cnt_q - 3'd1;
            if (dur_cnt_q == 3'd1) begin
              note_d    = REST;
              gap_cnt_d = 25'd0;
              state_d   = GAP;
            end
          end else begin
            unit_cnt_d = unit_cnt_q + 25'd1;
          end
        end

        GAP: begin
          if (gap_cnt_q == GAP_CYCLES) begin
            gap_cnt_d = 25'd0;
            idx_d     = idx_q + 3'd1;
            state_d   = LOAD;
          end else begin
            gap_cnt_d = gap_cnt_q + 25'd1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // A fresh pulse on the selection edge survives the clear: replay once more.
    pend_d = (pend_q & ~pend_clr) | {bus.req_die, bus.req_start, bus.req_eat};

    // mute only masks the output; sequencing runs on regardless.
    freq_d = bus.mute ? REST : note_d;
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      cur_seq_q  <= SEQ_NONE;
      pend_q     <= 3'b000;
      idx_q      <= 3'd0;
      note_q     <= REST;
      freq_q     <= REST;
      dur_cnt_q  <= 3'd0;
      unit_cnt_q <= 25'd0;
      gap_cnt_q  <= 25'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_seq_q  <= cur_seq_d;
      pend_q     <= pend_d;
      idx_q      <= idx_d;
      note_q     <= note_d;
      freq_q     <= freq_d;
      dur_cnt_q  <= dur_cnt_d;
      unit_cnt_q <= unit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.freq_data = freq_q;
  assign bus.busy      = busy_q;
  assign bus.cur_seq   = cur_seq_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_snake_sfx_sequencer.sv
// Bench for snake_sfx_sequencer with UNIT_CYCLES=9, GAP_CYCLES=1.
// Expected output is a list of runs of constant {busy, cur_seq, freq_data}
// with their lengths in cycles; length 0 means "any length" (idle between tests).
module tb_snake_sfx_sequencer;
  import snake_audio_pkg::*;

  localparam int SEG_W = 37;
  localparam logic [17:0] F_DO  = 18'd190839;
  localparam logic [17:0] F_MI  = 18'd151514;
  localparam logic [17:0] F_SO  = 18'd127550;
  localparam logic [17:0] F_HDO = 18'd95419;

  // Clock and reset.
  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  snake_sfx_sequencer_if bus();

  snake_sfx_sequencer #(
    .UNIT_CYCLES (25'd9),
    .GAP_CYCLES  (25'd1)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [SEG_W-1:0] exp_q[$];
  logic mon_en = 1'b0;

  // Driver tasks.
  task automatic drive_req(logic e, logic s, logic d);
    bus.req_eat   = e;
    bus.req_start = s;
    bus.req_die   = d;
    @(negedge sys_clk);
    bus.req_eat   = 1'b0;
    bus.req_start = 1'b0;
    bus.req_die   = 1'b0;
  endtask

  task automatic push_seg(logic b, logic [1:0] s, logic [17:0] f, int len);
    logic [15:0] l;
    l = len[15:0];
    exp_q.push_back({b, s, f, l});
  endtask

  task automatic push_note(logic [1:0] s, logic [17:0] f, int units);
    push_seg(1'b1, s, f, units * 10);
    push_seg(1'b1, s, 18'd0, 3);
  endtask

  task automatic push_seq(logic [1:0] s);
    push_seg(1'b1, s, 18'd0, 1);
    case (s)
      2'd1: begin
        push_note(s, F_SO, 1);
        push_note(s, F_HDO, 2);
      end
      2'd2: begin
        push_note(s, F_DO, 1);
        push_note(s, F_MI, 1);
        push_note(s, F_SO, 1);
        push_note(s, F_HDO, 3);
      end
      default: begin
        push_note(s, F_SO, 2);
        push_note(s, F_MI, 2);
        push_note(s, F_DO, 4);
      end
    endcase
  endtask

  task automatic push_idle(int len);
    push_seg(1'b0, 2'd0, 18'd0, len);
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic wait_drain(string name);
    int n;
    n = 0;
    while (exp_q.size() > 1 && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    checks++;
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL %s_drain got %0d segments left expected 1", name, exp_q.size());
      exp_q.delete();
      push_idle(0);
    end
  endtask

  // Scoreboard monitor: closes a run whenever the output tuple changes.
  logic [20:0]      run_t;
  logic [20:0]      cur_t;
  logic [SEG_W-1:0] e_seg;
  int               run_len;
  logic             have_run = 1'b0;

  initial begin
    forever begin
      @(negedge sys_clk);
      if (mon_en) begin
        cur_t = {bus.busy, bus.cur_seq, bus.freq_data};
        if (!have_run) begin
          run_t    = cur_t;
          run_len  = 1;
          have_run = 1'b1;
        end else if (cur_t == run_t) begin
          run_len++;
        end else begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_run got busy=%0d seq=%0d freq=%0d len=%0d expected no run",
                     run_t[20], run_t[19:18], run_t[17:0], run_len);
          end else begin
            e_seg = exp_q.pop_front();
            if (run_t != e_seg[SEG_W-1:16] ||
                (e_seg[15:0] != 16'd0 && e_seg[15:0] != run_len[15:0])) begin
              errors++;
              $display("FAIL run got busy=%0d seq=%0d freq=%0d len=%0d expected busy=%0d seq=%0d freq=%0d len=%0d",
                       run_t[20], run_t[19:18], run_t[17:0], run_len,
                       e_seg[36], e_seg[35:34], e_seg[33:16], e_seg[15:0]);
            end
          end
          run_t   = cur_t;
          run_len = 1;
        end
      end
    end
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Stimulus and final report.
  initial begin
    logic flag;
    bus.req_eat   = 1'b0;
    bus.req_start = 1'b0;
    bus.req_die   = 1'b0;
    bus.mute      = 1'b0;

    repeat (3) @(negedge sys_clk);
    chk("rst_freq", 32'(bus.freq_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_seq", 32'(bus.cur_seq), 32'd0);
    chk("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    sys_rst_n = 1'b1;
    push_idle(0);
    mon_en = 1'b1;
    repeat (2) @(negedge sys_clk);

    // 1: single eat
    push_seq(2'd1);
    push_idle(0);
    drive_req(1'b1, 1'b0, 1'b0);
    wait_drain("eat");

    // 2: eat and start together, start first then eat
    push_seq(2'd2);
    push_idle(1);
    push_seq(2'd1);
    push_idle(0);
    @(negedge sys_clk);
    drive_req(1'b1, 1'b1, 1'b0);
    wait_drain("eat_start");

    // 3: die during the second start note
    push_seg(1'b1, 2'd2, 18'd0, 1);
    push_note(2'd2, F_DO, 1);
    push_seg(1'b1, 2'd2, F_MI, 4);
    push_seq(2'd3);
    push_idle(0);
    @(negedge sys_clk);
    drive_req(1'b0, 1'b1, 1'b0);
    repeat (17) @(negedge sys_clk);
    drive_req(1'b0, 1'b0, 1'b1);
    wait_drain("preempt");

    // 4: three eat pulses during eat -> one replay
    push_seq(2'd1);
    push_idle(1);
    push_seq(2'd1);
    push_idle(0);
    @(negedge sys_clk);
    drive_req(1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge sys_clk);
    drive_req(1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge sys_clk);
    drive_req(1'b1, 1'b0, 1'b0);
    repeat (21) @(negedge sys_clk);
    drive_req(1'b1, 1'b0, 1'b0);
    wait_drain("collapse");

    // 5a: muted start, busy length unchanged
    push_seg(1'b1, 2'd2, 18'd0, 73);
    push_idle(0);
    @(negedge sys_clk);
    bus.mute = 1'b1;
    drive_req(1'b0, 1'b1, 1'b0);
    wait_drain("mute");

    // 5b: mute released mid first note
    push_seg(1'b1, 2'd2, 18'd0, 4);
    push_seg(1'b1, 2'd2, F_DO, 7);
    push_seg(1'b1, 2'd2, 18'd0, 3);
    push_note(2'd2, F_MI, 1);
    push_note(2'd2, F_SO, 1);
    push_note(2'd2, F_HDO, 3);
    push_idle(0);
    @(negedge sys_clk);
    drive_req(1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge sys_clk);
    bus.mute = 1'b0;
    wait_drain("unmute");

    // 6: asynchronous reset mid-PLAY with eat pending
    mon_en = 1'b0;
    repeat (2) @(negedge sys_clk);
    exp_q.delete();
    drive_req(1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge sys_clk);
    drive_req(1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge sys_clk);
    chk("pre_rst_freq", 32'(bus.freq_data), 32'(F_SO));
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    #3;
    sys_rst_n = 1'b0;
    #1;
    chk("async_rst_freq", 32'(bus.freq_data), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_seq", 32'(bus.cur_seq), 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    flag = 1'b0;
    repeat (40) begin
      @(negedge sys_clk);
      if (bus.busy || bus.freq_data != 18'd0 || bus.cur_seq != 2'd0) flag = 1'b1;
    end
    chk("post_rst_idle", 32'(flag), 32'd0);
    chk("post_rst_state", 32'(bus.dbg_state), 32'(IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
